// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU unit for the EX stage, results held in HI/LO.
// Ports: clk, reset, Start, Op, A, B, Cancel, HiLoWrite, HiLoSel, WData -> Busy, Done, HI, LO.
// Optional: define MDU_FAST_ZERO_EN to send zero multiplies and divide-by-zero straight to FIX.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cancel,
    input  logic             HiLoWrite,
    input  logic             HiLoSel,
    input  logic [WIDTH-1:0] WData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t state, state_n;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hreg;
    logic [WIDTH-1:0] lreg;
    logic [WIDTH-1:0] opnd;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;

    logic             op_div;
    logic             op_sgn;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             launch;
    logic             last;
    logic             fast;

    assign op_div = Op[1];
    assign op_sgn = ~Op[0];
    assign sa     = op_sgn & A[WIDTH-1];
    assign sb     = op_sgn & B[WIDTH-1];
    assign mag_a  = sa ? -A : A;
    assign mag_b  = sb ? -B : B;
    assign launch = (state == IDLE) && Start && !Cancel;
    assign last   = (cnt == CW'(WIDTH - 1));
    assign Busy   = (state != IDLE);

`ifdef MDU_FAST_ZERO_EN
    assign fast = op_div ? (B == '0) : ((A == '0) || (B == '0));
`else
    assign fast = 1'b0;
`endif

    // Multiply step: hreg accumulates, lreg holds the multiplier and
    // collects product low bits as the pair shifts right.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;

    assign mul_sum = {1'b0, hreg} + (lreg[0] ? {1'b0, opnd} : '0);
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], lreg[WIDTH-1:1]};

    // Divide step: hreg is the partial remainder, lreg shifts the
    // dividend out and quotient bits in. hreg < opnd holds throughout,
    // so the W-bit difference is exact whenever the subtract is taken.
    logic [WIDTH:0]   div_sh;
    logic             div_ok;
    logic [WIDTH-1:0] div_rem;

    assign div_sh  = {hreg, lreg[WIDTH-1]};
    assign div_ok  = (div_sh >= {1'b0, opnd});
    assign div_rem = div_sh[WIDTH-1:0] - opnd;

    // Sign correction applied in FIX.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               dz;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign dz       = (opnd == '0);
    assign prod_fix = neg_q ? -{hreg, lreg} : {hreg, lreg};
    assign quo_fix  = dz ? '1 : (neg_q ? -lreg : lreg);
    assign rem_fix  = neg_r ? -hreg : hreg;
    assign fix_hi   = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign fix_lo   = is_div ? quo_fix : prod_fix[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (launch) state_n = fast ? FIX : RUN;
            RUN: begin
                if (Cancel)    state_n = IDLE;
                else if (last) state_n = FIX;
            end
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            hreg   <= '0;
            lreg   <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (launch) begin
            cnt    <= '0;
            is_div <= op_div;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            hreg   <= '0;
            lreg   <= op_div ? mag_a : mag_b;
            opnd   <= op_div ? mag_b : mag_a;
            // Short path: preload what the full loop would have left.
            if (fast) begin
                hreg <= op_div ? mag_a : '0;
                lreg <= '0;
            end
        end else if (state == RUN && !Cancel) begin
            cnt <= cnt + CW'(1);
            if (is_div) begin
                hreg <= div_ok ? div_rem : div_sh[WIDTH-1:0];
                lreg <= {lreg[WIDTH-2:0], div_ok};
            end else begin
                hreg <= mul_hi;
                lreg <= mul_lo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            HI   <= '0;
            LO   <= '0;
            Done <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (state == FIX && !Cancel) begin
                HI   <= fix_hi;
                LO   <= fix_lo;
                Done <= 1'b1;
            end else if (state == IDLE && HiLoWrite) begin
                if (HiLoSel) HI <= WData;
                else         LO <= WData;
            end
        end
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage, alongside the ALU.
- Takes the same A/B operands as the ALU and executes MULT/MULTU/DIV/DIVU over multiple cycles into HI/LO.
- HI/LO feed the EX result mux for MFHI/MFLO.
- Busy is used by the hazard unit to stall MFHI/MFLO/MTHI/MTLO and new mul/div issue.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- Start  input  1  launch operation; sampled only when Busy=0
- Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- A  input  WIDTH  rs operand (multiplicand/dividend)
- B  input  WIDTH  rt operand (multiplier/divisor)
- Cancel  input  1  pipeline flush; abandons in-flight op
- HiLoWrite  input  1  MTHI/MTLO write strobe
- HiLoSel  input  1  0 writes LO, 1 writes HI
- WData  input  WIDTH  MTHI/MTLO data
- Busy  output  1  operation in progress
- Done  output  1  one-cycle pulse: HI/LO now hold new result
- HI  output  WIDTH  HI register
- LO  output  WIDTH  LO register

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset: state IDLE; HI=0, LO=0, Busy=0, Done=0; all internal datapath registers cleared. Reset mid-operation abandons it with no Done.
- States:
  - IDLE: Start=1 latches |A|, |B| (signed ops) or raw A, B (unsigned), plus sign flags. Goes to RUN, iteration counter=0.
  - RUN: one iteration per cycle. Multiply is radix-2 shift-add into a 2*WIDTH accumulator. Divide is restoring shift-subtract producing quotient and remainder. After WIDTH iterations goes to FIX.
  - FIX: sign correction, write HI/LO, Done<=1, go to IDLE.
- Timing: Start accepted at edge E0. Busy=1 after E0 through E(WIDTH+1). HI/LO written at E(WIDTH+1). Done=1 for the following cycle only. Latency is 33 cycles for WIDTH=32.
- Results:
  - MULT/MULTU: {HI,LO} = full 2*WIDTH product. For MULT, the product is negated when signA^signB.
  - DIV/DIVU: LO=quotient, HI=remainder. For DIV, the quotient is negated when signA^signB, and the remainder takes the sign of A.
- Divide by zero (DIV or DIVU, B=0): full latency, LO=all ones, HI=A.
- DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0 (truncating magnitude arithmetic).
- Start while Busy=1: ignored.
- Start in the same cycle Done=1: accepted, since the state is IDLE.
- Cancel: takes priority over Start and progress. State goes to IDLE next edge, Busy=0, HI/LO unchanged, no Done. Cancel in IDLE has no effect.
- HiLoWrite:
  - Honored only when Busy=0; the selected register gets WData next edge.
  - If Start and HiLoWrite arrive together in IDLE, the write is performed and the op is still launched; the op result later overwrites both.
  - While Busy=1, HiLoWrite is ignored; the hazard unit must stall.
- Priority at each edge: reset > Cancel > FIX write > HiLoWrite > Start.
- HI/LO change only on FIX, HiLoWrite, or reset.

Optional Feature:
- Macro: MDU_FAST_ZERO_EN.
- Defined:
  - In IDLE, Start with a multiply where A=0 or B=0 goes straight to FIX. Result HI=0, LO=0; Done follows 2 cycles after Start.
  - DIV/DIVU with B=0 also goes straight to FIX, giving the divide-by-zero result above with the same short latency.
- Undefined: all operations take the full WIDTH+1 cycles. Results are identical either way.

Test Plan:
- MULT A=0xFFFFFFFE (-2), B=0x00000003 -> after 33 cycles Done=1, HI=0xFFFFFFFF, LO=0xFFFFFFFA; Busy high for exactly 33 cycles.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU A=7, B=2 -> LO=3, HI=1.
- DIVU A=0x12345678, B=0 -> LO=0xFFFFFFFF, HI=0x12345678. With MDU_FAST_ZERO_EN, Done 2 cycles after Start.
- Start MULT, Cancel at cycle 10 with HI=0xAAAA0000, LO=0x0000BBBB preloaded -> Busy=0 next cycle, no Done, HI/LO unchanged. Start during Busy -> ignored. HiLoWrite during Busy -> ignored.
- Reset asserted mid-DIV -> next cycle Busy=0, Done=0, HI=LO=0. Then HiLoWrite HiLoSel=1 WData=0x5 -> HI=0x5, LO=0.
